wb_sequencer: RTL

- Writeback controller for the 8-bit core's 5-input writeback select mux (ALU, data memory, LUT LSW, LUT MSW, immediate).
- Accepts one writeback request per issue from decode.
- Drives the mux select, register-file write enable and write address.
- Sequences multi-cycle cases (data-memory load wait, two-word LUT writeback) and stalls the front end while busy.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/wb_pkg.sv
// Shared types and mux-select encodings for the writeback sequencer.
package wb_pkg;

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_ALU  = 3'd1,
    KIND_LOAD = 3'd2,
    KIND_LUT  = 3'd3,
    KIND_IMM  = 3'd4
  } wb_kind_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_LUT_MSW   = 2'd2
  } wb_state_e;

  localparam logic [3:0] SEL_ALU     = 4'd0;
  localparam logic [3:0] SEL_MEM     = 4'd1;
  localparam logic [3:0] SEL_LUT_LSW = 4'd2;
  localparam logic [3:0] SEL_LUT_MSW = 4'd3;
  localparam logic [3:0] SEL_IMM     = 4'd4;

endpackage

// File: rtl/wb_sequencer.sv
// Writeback controller: drives mux select / RF write for ALU, IMM, LOAD and two-word LUT results.
// Optional WB_TIMEOUT_EN adds a LOAD_WAIT abort after LD_TIMEOUT cycles with a sticky ld_timeout flag.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int RF_AW      = 3,
  parameter int LD_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [2:0]       issue_kind,
  input  logic [RF_AW-1:0] issue_rd,
  input  logic             mem_valid,
  output logic [3:0]       mux_sel,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic             stall,
  output logic [7:0]       wb_count,
  output logic             ld_timeout
);

  if (LD_TIMEOUT < 1 || LD_TIMEOUT > 31) begin : g_ld_timeout_range
    $error("LD_TIMEOUT must fit the 5-bit load-wait counter (1..31)");
  end

  wb_state_e        state;
  logic [RF_AW-1:0] rd_q;

`ifdef WB_TIMEOUT_EN
  logic [4:0] ld_cnt;
`else
  assign ld_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rf_we    <= 1'b0;
      mux_sel  <= SEL_ALU;
      rf_waddr <= '0;
      stall    <= 1'b0;
      wb_count <= 8'd0;
      rd_q     <= '0;
`ifdef WB_TIMEOUT_EN
      ld_cnt     <= 5'd0;
      ld_timeout <= 1'b0;
`endif
    end else begin
      // mux_sel parks at ALU whenever no write is issued this cycle
      rf_we   <= 1'b0;
      mux_sel <= SEL_ALU;
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            case (issue_kind)
              KIND_ALU: begin
                rf_we    <= 1'b1;
                mux_sel  <= SEL_ALU;
                rf_waddr <= issue_rd;
                wb_count <= wb_count + 8'd1;
              end
              KIND_IMM: begin
                rf_we    <= 1'b1;
                mux_sel  <= SEL_IMM;
                rf_waddr <= issue_rd;
                wb_count <= wb_count + 8'd1;
              end
              KIND_LOAD: begin
                state <= S_LOAD_WAIT;
                stall <= 1'b1;
                rd_q  <= issue_rd;
`ifdef WB_TIMEOUT_EN
                ld_cnt <= 5'd0;
`endif
              end
              KIND_LUT: begin
                rf_we    <= 1'b1;
                mux_sel  <= SEL_LUT_LSW;
                rf_waddr <= issue_rd;
                wb_count <= wb_count + 8'd1;
                rd_q     <= issue_rd;
                state    <= S_LUT_MSW;
                stall    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_LUT_MSW: begin
          rf_we    <= 1'b1;
          mux_sel  <= SEL_LUT_MSW;
          rf_waddr <= rd_q + RF_AW'(1);
          wb_count <= wb_count + 8'd1;
          state    <= S_IDLE;
          stall    <= 1'b0;
        end
        S_LOAD_WAIT: begin
          if (mem_valid) begin
            rf_we    <= 1'b1;
            mux_sel  <= SEL_MEM;
            rf_waddr <= rd_q;
            wb_count <= wb_count + 8'd1;
            state    <= S_IDLE;
            stall    <= 1'b0;
          end
`ifdef WB_TIMEOUT_EN
          // final permitted cycle: mem_valid above has priority over the abort
          else if (ld_cnt == 5'(LD_TIMEOUT - 1)) begin
            state      <= S_IDLE;
            stall      <= 1'b0;
            ld_timeout <= 1'b1;
          end else begin
            ld_cnt <= ld_cnt + 5'd1;
          end
`endif
        end
        default: begin
          state <= S_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
